// File: rtl/pad_seq_pkg.sv
// Shared types and constants for the pad mux sequencer: FSM state encoding,
// pad cfg bit positions and sizing helpers.
package pad_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        APPLY   = 2'd2,
        SETTLE  = 2'd3
    } pad_seq_state_e;

    localparam int PD   = 0;
    localparam int PU   = 1;
    localparam int SMT  = 2;
    localparam int SR   = 3;
    localparam int PIN1 = 4;
    localparam int PIN2 = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the largest reload value of either wait phase.
    function automatic int cnt_width(input int q, input int s);
        return $clog2(max_int(q, s) + 1);
    endfunction

endpackage

// File: rtl/pad_rr_arbiter.sv
// Round-robin pick of the first pending pad at or above rr_ptr, wrapping to 0.
// Purely combinational.
module pad_rr_arbiter #(
    parameter  int N_PADS = 32,
    localparam int IDX_W  = $clog2(N_PADS)
) (
    input  logic [N_PADS-1:0] pending,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        int pos;
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        // Walk from the farthest offset down so the nearest pending pad wins.
        for (int k = N_PADS - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N_PADS) pos = pos - N_PADS;
            if (pending[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pad_mux_sequencer.sv
// Applies requested pad mux/cfg changes one pad at a time, holding the pad's
// output enable off for a quiesce window before and a settle window after the switch.
module pad_mux_sequencer
    import pad_seq_pkg::*;
#(
    parameter int N_PADS         = 32,
    parameter int CFG_W          = PIN2 + 1,
    parameter int QUIESCE_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [N_PADS-1:0]             pad_mux_i,
    input  logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_i,
    output logic [N_PADS-1:0]             pad_mux_o,
    output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
    output logic [N_PADS-1:0]             pad_oe_gate_o,
    output logic                          busy_o,
    output logic                          update_done_o
);

    localparam int IDX_W = $clog2(N_PADS);
    localparam int CNT_W = cnt_width(QUIESCE_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] Q_LOAD   = CNT_W'(QUIESCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PADS - 1);

    pad_seq_state_e                  state, state_nxt;
    logic [CNT_W-1:0]                cnt, cnt_nxt;
    logic [IDX_W-1:0]                cur_idx, cur_idx_nxt;
    logic [IDX_W-1:0]                rr_ptr, rr_ptr_nxt;
    logic [N_PADS-1:0]               pending;
    logic                            arb_valid;
    logic [IDX_W-1:0]                arb_idx;
    logic [N_PADS-1:0]               mux_nxt;
    logic [N_PADS-1:0][CFG_W-1:0]    cfg_nxt;
    logic [N_PADS-1:0]               gate_nxt;
    logic                            busy_nxt;
    logic                            done_nxt;

    always_comb begin
        pending = '0;
        for (int i = 0; i < N_PADS; i++) begin
            pending[i] = (pad_mux_i[i] != pad_mux_o[i]) || (pad_cfg_i[i] != pad_cfg_o[i]);
        end
    end

    pad_rr_arbiter #(.N_PADS(N_PADS)) u_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .valid   (arb_valid),
        .idx     (arb_idx)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= IDLE;
            cnt           <= '0;
            cur_idx       <= '0;
            rr_ptr        <= '0;
            pad_mux_o     <= '0;
            pad_cfg_o     <= '0;
            pad_oe_gate_o <= '1;
            busy_o        <= 1'b0;
            update_done_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cur_idx       <= cur_idx_nxt;
            rr_ptr        <= rr_ptr_nxt;
            pad_mux_o     <= mux_nxt;
            pad_cfg_o     <= cfg_nxt;
            pad_oe_gate_o <= gate_nxt;
            busy_o        <= busy_nxt;
            update_done_o <= done_nxt;
        end
    end

    // IDLE picks a pad | QUIESCE gate low | APPLY switch | SETTLE gate low, then release
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_idx_nxt = cur_idx;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    cur_idx_nxt = arb_idx;
                    cnt_nxt     = Q_LOAD;
                    state_nxt   = QUIESCE;
                end
            end
            QUIESCE: begin
                if (cnt == '0) state_nxt = APPLY;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            APPLY: begin
                cnt_nxt   = S_LOAD;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mux_nxt    = pad_mux_o;
        cfg_nxt    = pad_cfg_o;
        gate_nxt   = pad_oe_gate_o;
        rr_ptr_nxt = rr_ptr;
        done_nxt   = 1'b0;
        busy_nxt   = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (arb_valid) gate_nxt[arb_idx] = 1'b0;
            end
            APPLY: begin
                mux_nxt[cur_idx] = pad_mux_i[cur_idx];
                cfg_nxt[cur_idx] = pad_cfg_i[cur_idx];
            end
            SETTLE: begin
                if (cnt == '0) begin
                    gate_nxt[cur_idx] = 1'b1;
                    done_nxt          = 1'b1;
                    rr_ptr_nxt        = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
